// File: rtl/alu_arbiter_if.sv
// Bundle of the requester handshakes, the ALU operand/result wires and the
// response port shared by alu_arbiter and whatever sits around it.
interface alu_arbiter_if #(parameter int n = 64);
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [n-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_ctrl, req1_ctrl;
    logic [n-1:0] alu_a, alu_b, alu_w;
    logic [3:0]   alu_ctrl;
    logic         alu_zero;
    logic         rsp_valid, rsp_id, rsp_zero, rsp_err;
    logic [n-1:0] rsp_w;

    // Requesters plus the ALU itself
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_ctrl, req1_ctrl, alu_w, alu_zero,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
               rsp_valid, rsp_id, rsp_w, rsp_zero, rsp_err
    );

    // The arbiter
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_ctrl, req1_ctrl, alu_w, alu_zero,
        output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
               rsp_valid, rsp_id, rsp_w, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters: one op
// in flight, operands held LAT cycles, result returned as a tagged one-cycle pulse.
module alu_arbiter #(
    parameter int n   = 64,
    parameter int LAT = 2
) (
    input logic          CLK,
    input logic          Reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} stateType;

    stateType     state, stateNext;
    logic         lastServed, curId, errFlag;
    logic         anyValid, grant, accept, selLegal;
    logic [3:0]   settleCnt;
    logic [n-1:0] selA, selB;
    logic [3:0]   selCtrl;

    function automatic logic isLegal(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: isLegal = 1'b1;
            default:                                     isLegal = 1'b0;
        endcase
    endfunction

    // On a tie the requester not served last wins; a lone requester always wins.
    assign anyValid = bus.req0_valid | bus.req1_valid;
    assign grant    = (bus.req0_valid && bus.req1_valid) ? ~lastServed : bus.req1_valid;
    assign selA     = grant ? bus.req1_a    : bus.req0_a;
    assign selB     = grant ? bus.req1_b    : bus.req0_b;
    assign selCtrl  = grant ? bus.req1_ctrl : bus.req0_ctrl;
    assign selLegal = isLegal(selCtrl);
    assign accept   = (state == IDLE) && anyValid && !Reset;

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // NOTE: every output of this block gets a default first; without it, any
    // path that skips an assignment would infer a latch.
    always_comb begin
        stateNext      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_err    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                    stateNext      = selLegal ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (settleCnt == 4'd0) stateNext = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = errFlag;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_ctrl <= 4'b0000;
            bus.rsp_id   <= 1'b0;
            bus.rsp_w    <= '0;
            bus.rsp_zero <= 1'b0;
            lastServed   <= 1'b1;
            curId        <= 1'b0;
            errFlag      <= 1'b0;
            settleCnt    <= 4'd0;
        end else begin
            if (accept) begin
                curId      <= grant;
                lastServed <= grant;
                if (selLegal) begin
                    bus.alu_a    <= selA;
                    bus.alu_b    <= selB;
                    bus.alu_ctrl <= selCtrl;
                    settleCnt    <= 4'(LAT - 1);
                    errFlag      <= 1'b0;
                end else begin
                    // Rejected op leaves the ALU inputs untouched
                    errFlag      <= 1'b1;
                    bus.rsp_id   <= grant;
                    bus.rsp_w    <= '0;
                    bus.rsp_zero <= 1'b0;
                end
            end
            if (state == EXEC) begin
                if (settleCnt == 4'd0) begin
                    bus.rsp_w    <= bus.alu_w;
                    bus.rsp_zero <= bus.alu_zero;
                    bus.rsp_id   <= curId;
                end else begin
                    settleCnt <= settleCnt - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with LAT=3 and a 10 ns clock; the ALU is a
// small combinational model driven from the arbiter's alu_* outputs.
module tb_alu_arbiter;
    localparam int N   = 64;
    localparam int LAT = 3;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    alu_arbiter_if #(.n(N)) bus ();
    alu_arbiter #(.n(N), .LAT(LAT)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always_comb begin
        bus.alu_w = '0;
        case (bus.alu_ctrl)
            4'b0000: bus.alu_w = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_w = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_w = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_w = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_w = bus.alu_b;
            default: bus.alu_w = '0;
        endcase
    end
    assign bus.alu_zero = (bus.alu_w == '0);

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Raise valid for one requester and hold it until the accept edge.
    task automatic drive_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                             input logic [3:0] ctrl, output logic accepted);
        logic rdy;
        accepted = 1'b0;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl; bus.req0_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            rdy = id ? bus.req1_ready : bus.req0_ready;
            step();
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    // Cycles from the accept edge to the response pulse, -1 on timeout.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!bus.rsp_valid && cycles < 20) begin
            step();
            cycles++;
        end
        if (!bus.rsp_valid) cycles = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step();
        step();
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", bus.req1_ready); end
        total++; if (bus.alu_a !== 64'd0 || bus.alu_b !== 64'd0 || bus.alu_ctrl !== 4'd0) begin
            bad++; $display("FAIL rst_alu got a=%0h b=%0h ctrl=%b exp=0", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
        total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err} !== 4'b0000 || bus.rsp_w !== 64'd0) begin
            bad++; $display("FAIL rst_rsp got v=%b id=%b z=%b e=%b w=%0h exp=0", bus.rsp_valid, bus.rsp_id,
                            bus.rsp_zero, bus.rsp_err, bus.rsp_w); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_single_add();
        logic acc;
        drive_req(1'b0, 64'd5, 64'd7, 4'b0010, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL add_accept got=%b exp=1", acc); end
        for (int i = 0; i < LAT; i++) begin
            total++; if (bus.alu_ctrl !== 4'b0010 || bus.rsp_valid !== 1'b0) begin
                bad++; $display("FAIL add_hold cyc=%0d got ctrl=%b v=%b exp ctrl=0010 v=0", i, bus.alu_ctrl, bus.rsp_valid); end
            step();
        end
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL add_pulse got=%b exp=1", bus.rsp_valid); end
        total++; if (bus.rsp_w !== 64'd12) begin bad++; $display("FAIL add_w got=%0h exp=c", bus.rsp_w); end
        total++; if ({bus.rsp_id, bus.rsp_zero, bus.rsp_err} !== 3'b000) begin
            bad++; $display("FAIL add_flags got id/z/e=%b exp=000", {bus.rsp_id, bus.rsp_zero, bus.rsp_err}); end
        step();
        total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_w !== 64'd12) begin
            bad++; $display("FAIL add_after got v=%b w=%0h exp v=0 w=c", bus.rsp_valid, bus.rsp_w); end
    endtask

    task automatic test_sub_zero();
        logic acc;
        int   cyc;
        drive_req(1'b1, 64'h1234, 64'h1234, 4'b0110, acc);
        wait_rsp(cyc);
        total++; if (acc !== 1'b1 || cyc !== LAT) begin bad++; $display("FAIL sub_latency got acc=%b cyc=%0d exp acc=1 cyc=%0d", acc, cyc, LAT); end
        total++; if (bus.rsp_w !== 64'd0 || bus.rsp_zero !== 1'b1) begin
            bad++; $display("FAIL sub_result got w=%0h z=%b exp w=0 z=1", bus.rsp_w, bus.rsp_zero); end
        total++; if (bus.rsp_id !== 1'b1 || bus.rsp_err !== 1'b0) begin
            bad++; $display("FAIL sub_id got id=%b e=%b exp id=1 e=0", bus.rsp_id, bus.rsp_err); end
        step();
    endtask

    task automatic test_contention();
        logic        grants[$];
        logic [63:0] rspW[$];
        logic        rspId[$];
        int          rspCyc[$];
        logic [63:0] expW[4] = '{64'hFF, 64'hAA, 64'hFF, 64'hAA};
        logic        expId[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        r0, r1;
        bus.req0_a = 64'hF0; bus.req0_b = 64'h0F; bus.req0_ctrl = 4'b0001;
        bus.req1_a = 64'h55; bus.req1_b = 64'hAA; bus.req1_ctrl = 4'b0111;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 60 && rspW.size() < 4; cyc++) begin
            r0 = bus.req0_ready;
            r1 = bus.req1_ready;
            total++; if (r0 && r1) begin bad++; $display("FAIL both_ready cyc=%0d got=11 exp=one-hot", cyc); end
            if (r0) grants.push_back(1'b0);
            else if (r1) grants.push_back(1'b1);
            step();
            if (bus.rsp_valid) begin
                rspW.push_back(bus.rsp_w);
                rspId.push_back(bus.rsp_id);
                rspCyc.push_back(cyc);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        total++; if (grants.size() != 4 || rspW.size() != 4) begin
            bad++; $display("FAIL cont_count got grants=%0d rsps=%0d exp 4/4", grants.size(), rspW.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (grants[i] !== expId[i] || rspId[i] !== expId[i] || rspW[i] !== expW[i]) begin
                    bad++; $display("FAIL cont_op%0d got grant=%b id=%b w=%0h exp grant/id=%b w=%0h",
                                    i, grants[i], rspId[i], rspW[i], expId[i], expW[i]); end
            end
            for (int i = 1; i < 4; i++) begin
                total++; if (rspCyc[i] - rspCyc[i-1] != LAT + 2) begin
                    bad++; $display("FAIL cont_spacing%0d got=%0d exp=%0d", i, rspCyc[i] - rspCyc[i-1], LAT + 2); end
            end
        end
        step();
    endtask

    task automatic test_illegal();
        logic acc;
        int   cyc;
        drive_req(1'b0, 64'h99, 64'h77, 4'b0011, acc);
        wait_rsp(cyc);
        total++; if (acc !== 1'b1 || cyc !== 0) begin bad++; $display("FAIL ill_latency got acc=%b cyc=%0d exp acc=1 cyc=0", acc, cyc); end
        total++; if (bus.alu_a !== 64'h55 || bus.alu_b !== 64'hAA || bus.alu_ctrl !== 4'b0111) begin
            bad++; $display("FAIL ill_alu got a=%0h b=%0h ctrl=%b exp a=55 b=aa ctrl=0111", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
        total++; if (bus.rsp_err !== 1'b1 || bus.rsp_w !== 64'd0 || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0) begin
            bad++; $display("FAIL ill_rsp got e=%b w=%0h z=%b id=%b exp e=1 w=0 z=0 id=0", bus.rsp_err, bus.rsp_w, bus.rsp_zero, bus.rsp_id); end
        step();
        total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            bad++; $display("FAIL ill_after got v=%b e=%b exp 0 0", bus.rsp_valid, bus.rsp_err); end
        bus.req1_valid = 1'b1;
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL ill_next_ready got=%b exp=1", bus.req1_ready); end
        bus.req1_valid = 1'b0;
        step();
    endtask

    task automatic test_negative_add();
        logic acc;
        int   cyc;
        drive_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 4'b0010, acc);
        wait_rsp(cyc);
        total++; if (acc !== 1'b1 || cyc !== LAT) begin bad++; $display("FAIL neg_latency got acc=%b cyc=%0d exp acc=1 cyc=%0d", acc, cyc, LAT); end
        total++; if (bus.rsp_w !== 64'hFFFF_FFFF_FFFF_FFFE || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b1) begin
            bad++; $display("FAIL neg_result got w=%0h z=%b id=%b exp w=fffffffffffffffe z=0 id=1", bus.rsp_w, bus.rsp_zero, bus.rsp_id); end
    endtask

    task automatic test_reset_mid_exec();
        logic acc;
        logic sawPulse;
        drive_req(1'b0, 64'd1, 64'd2, 4'b0010, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b exp=1", acc); end
        Reset = 1'b1;
        step();
        total++; if (bus.alu_a !== 64'd0 || bus.alu_b !== 64'd0 || bus.alu_ctrl !== 4'd0) begin
            bad++; $display("FAIL mid_alu got a=%0h b=%0h ctrl=%b exp=0", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
        total++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err} !== 4'b0000 || bus.rsp_w !== 64'd0) begin
            bad++; $display("FAIL mid_rsp got v=%b id=%b z=%b e=%b w=%0h exp=0", bus.rsp_valid, bus.rsp_id,
                            bus.rsp_zero, bus.rsp_err, bus.rsp_w); end
        Reset = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL mid_tie got r0=%b r1=%b exp r0=1 r1=0", bus.req0_ready, bus.req1_ready); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        sawPulse = 1'b0;
        for (int i = 0; i < 2 * LAT + 2; i++) begin
            step();
            if (bus.rsp_valid) sawPulse = 1'b1;
        end
        total++; if (sawPulse !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got=%b exp=0", sawPulse); end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
        #1;
        test_reset();
        test_single_add();
        test_sub_zero();
        test_contention();
        test_illegal();
        test_negative_add();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
